// File: rtl/jk_cmd_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// jk_pkg: shared types for the JK command sequencer.
//   - jk_op_e    : command opcodes (HOLD/SET/CLR/TOG)
//   - jk_state_e : sequencer FSM states
//   - jk_cmd_t   : one queued command {op, len}
//   - jk_enc()   : opcode to {j, k} excitation
// ---------------------------------------------------------------------------
package jk_pkg;

    // Width of the repeat-length field carried in jk_cmd_t. The sequencer's
    // LEN_W parameter defaults to this and must stay equal to it.
    localparam int unsigned CMD_LEN_W = 4;

    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_SET  = 2'd1,
        OP_CLR  = 2'd2,
        OP_TOG  = 2'd3
    } jk_op_e;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StDrive,
        StCheck
    } jk_state_e;

    typedef struct packed {
        jk_op_e               op;
        logic [CMD_LEN_W-1:0] len;
    } jk_cmd_t;

    // Returns {j, k}.
    function automatic logic [1:0] jk_enc(input jk_op_e op);
        logic [1:0] enc;
        unique case (op)
            OP_HOLD: enc = 2'b00;
            OP_SET:  enc = 2'b10;
            OP_CLR:  enc = 2'b01;
            OP_TOG:  enc = 2'b11;
            default: enc = 2'b00;
        endcase
        return enc;
    endfunction

endpackage

// File: rtl/jk_cmd_sequencer_if.sv
// ---------------------------------------------------------------------------
// jk_cmd_sequencer_if: command valid/ready channel into the sequencer.
//   cmd_valid : command offered (master -> slave)
//   cmd_ready : slave can accept (slave -> master)
//   cmd_op    : opcode, 0=HOLD 1=SET 2=CLR 3=TOG
//   cmd_len   : repeat count minus one
// ---------------------------------------------------------------------------
interface jk_cmd_sequencer_if
    import jk_pkg::*;
#(
    parameter int unsigned LEN_W = CMD_LEN_W
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [LEN_W-1:0] cmd_len;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_len,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_len,
        output cmd_ready
    );
endinterface

// File: rtl/jk_cmd_sequencer_fifo.sv
// ---------------------------------------------------------------------------
// jk_cmd_fifo: synchronous FIFO of jk_cmd_t entries.
//   clk, reset : clock, asynchronous active-low reset
//   i_push     : write i_wdata (ignored while full)
//   i_pop      : drop head entry (ignored while empty)
//   o_rdata    : head entry, valid while !o_empty
//   o_full, o_empty, o_count : occupancy status
// Pointers carry one extra MSB so full and empty are distinguishable and
// wrap by natural rollover.
// ---------------------------------------------------------------------------
module jk_cmd_fifo
    import jk_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  jk_cmd_t                  i_wdata,
    input  logic                     i_pop,
    output jk_cmd_t                  o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    jk_cmd_t     r_mem [DEPTH];
    logic        w_do_push;
    logic        w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_count   = r_wr_ptr - r_rd_ptr;
    assign o_rdata   = r_mem[r_rd_ptr[AW-1:0]];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/jk_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// jk_cmd_sequencer: drives j/k excitation into a downstream JK flip-flop from
// a queue of {op, len} commands and checks the flip-flop's q afterwards.
//   clk, reset  : clock, asynchronous active-low reset
//   cmd_if      : command valid/ready channel (slave side)
//   q_fb        : q of the downstream flip-flop
//   j, k        : registered excitation, non-zero only in DRIVE
//   busy        : high in LOAD, DRIVE and CHECK
//   done        : one-cycle pulse in CHECK
//   err         : sticky q mismatch flag, cleared by err_clr (set wins)
//   fifo_count  : command FIFO occupancy
// ---------------------------------------------------------------------------
module jk_cmd_sequencer
    import jk_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned LEN_W = CMD_LEN_W
) (
    input  logic                   clk,
    input  logic                   reset,
    jk_cmd_sequencer_if.slave      cmd_if,
    input  logic                   q_fb,
    output logic                   j,
    output logic                   k,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    input  logic                   err_clr,
    output logic [$clog2(DEPTH):0] fifo_count
);
    jk_cmd_t    w_push_cmd;
    jk_cmd_t    w_head;
    logic       w_full;
    logic       w_empty;
    logic       w_pop;

    jk_state_e  r_state;
    jk_state_e  w_state_d;
    jk_op_e     r_op;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_cnt;
    logic [LEN_W-1:0] w_cnt_d;
    logic       r_q_start;
    logic       r_j;
    logic       r_k;
    logic       w_j_d;
    logic       w_k_d;
    logic       r_err;
    logic       w_check;
    logic       w_exp_q;
    logic       w_mismatch;

    assign w_push_cmd.op  = jk_op_e'(cmd_if.cmd_op);
    assign w_push_cmd.len = cmd_if.cmd_len;
    assign cmd_if.cmd_ready = !w_full;

    jk_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (cmd_if.cmd_valid),
        .i_wdata (w_push_cmd),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (fifo_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= StIdle;
        else        r_state <= w_state_d;
    end

    always_comb begin
        w_state_d = r_state;
        w_pop     = 1'b0;
        w_cnt_d   = r_cnt;
        w_j_d     = r_j;
        w_k_d     = r_k;
        w_check   = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (!w_empty) begin
                    w_pop     = 1'b1;
                    w_state_d = StLoad;
                end
            end
            StLoad: begin
                w_cnt_d        = r_len;
                {w_j_d, w_k_d} = jk_enc(r_op);
                w_state_d      = StDrive;
            end
            StDrive: begin
                // j/k drop on the same edge that enters CHECK, so the
                // flip-flop sees exactly len+1 excited edges.
                if (r_cnt == '0) begin
                    w_j_d     = 1'b0;
                    w_k_d     = 1'b0;
                    w_state_d = StCheck;
                end else begin
                    w_cnt_d = r_cnt - LEN_W'(1);
                end
            end
            StCheck: begin
                w_check   = 1'b1;
                w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Toggle flips q once per driven edge, i.e. len+1 times.
    always_comb begin
        w_exp_q = r_q_start;
        unique case (r_op)
            OP_HOLD: w_exp_q = r_q_start;
            OP_SET:  w_exp_q = 1'b1;
            OP_CLR:  w_exp_q = 1'b0;
            OP_TOG:  w_exp_q = r_q_start ^ ~r_len[0];
            default: w_exp_q = r_q_start;
        endcase
    end

    assign w_mismatch = w_check && (q_fb != w_exp_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op      <= OP_HOLD;
            r_len     <= '0;
            r_q_start <= 1'b0;
            r_cnt     <= '0;
            r_j       <= 1'b0;
            r_k       <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            if (w_pop) begin
                r_op      <= w_head.op;
                r_len     <= w_head.len;
                r_q_start <= q_fb;
            end
            r_cnt <= w_cnt_d;
            r_j   <= w_j_d;
            r_k   <= w_k_d;
            if (w_mismatch)   r_err <= 1'b1;
            else if (err_clr) r_err <= 1'b0;
        end
    end

    assign j    = r_j;
    assign k    = r_k;
    assign busy = (r_state != StIdle);
    assign done = (r_state == StCheck);
    assign err  = r_err;

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
module tb_jk_cmd_sequencer;
    import jk_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned LEN_W = 4;

    typedef struct {
        logic [1:0] op;
        logic [3:0] len;
    } cmd_s;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       q_fb;
    logic       j, k, busy, done, err;
    logic       err_clr;
    logic [2:0] fifo_count;

    always #5 clk = ~clk;

    jk_cmd_sequencer_if #(.LEN_W(LEN_W)) cmd_if ();

    jk_cmd_sequencer #(
        .DEPTH (DEPTH),
        .LEN_W (LEN_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_if     (cmd_if),
        .q_fb       (q_fb),
        .j          (j),
        .k          (k),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .err_clr    (err_clr),
        .fifo_count (fifo_count)
    );

    // Downstream JK flip-flop model (not reset by the sequencer).
    logic ff_q = 1'b0;
    logic stuck = 1'b0;
    always @(posedge clk) begin
        case ({j, k})
            2'b10:   ff_q <= 1'b1;
            2'b01:   ff_q <= 1'b0;
            2'b11:   ff_q <= ~ff_q;
            default: ff_q <= ff_q;
        endcase
    end
    assign q_fb = stuck ? 1'b0 : ff_q;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    cmd_s       sb_q[$];
    logic [1:0] seq[$];
    logic [1:0] enc_tab [4] = '{2'b00, 2'b10, 2'b01, 2'b11};  // {j,k} per op

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: event missing or unexpected (t=%0t)", name, $time);
    endtask

    function automatic logic exp_final(input logic [1:0] op, input logic [3:0] len,
                                       input logic q0);
        int toggles;
        toggles = int'(len) + 1;
        case (op)
            2'd0:    return q0;
            2'd1:    return 1'b1;
            2'd2:    return 1'b0;
            default: return (toggles % 2 == 1) ? ~q0 : q0;
        endcase
    endfunction

    // Monitor: collects j/k per busy cycle, checks each command at done.
    initial begin : monitor
        cmd_s       c;
        logic       q_start;
        logic       exp_err;
        logic       mism;
        logic       eq;
        logic [1:0] e_jk;
        int         n;
        int         nbad;
        exp_err = 1'b0;
        q_start = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                seq.delete();
                exp_err = 1'b0;
            end else begin
                check("err_flag", err, exp_err);
                if (busy) begin
                    if (seq.size() == 0) q_start = q_fb;
                    seq.push_back({j, k});
                end
                mism = 1'b0;
                if (done) begin
                    if (sb_q.size() == 0) begin
                        fail("unexpected_done");
                    end else begin
                        c = sb_q.pop_front();
                        n = int'(c.len) + 3;
                        check("busy_cycles", seq.size(), n);
                        nbad = 0;
                        for (int i = 0; i < seq.size(); i++) begin
                            if (i == 0 || i >= n - 1) e_jk = 2'b00;
                            else                      e_jk = enc_tab[c.op];
                            if (seq[i] !== e_jk) nbad++;
                        end
                        check("jk_sequence", nbad, 0);
                        eq = exp_final(c.op, c.len, q_start);
                        if (!stuck) check("final_q", q_fb, eq);
                        mism = (q_fb !== eq);
                    end
                    seq.delete();
                end
                exp_err = mism | (exp_err & ~err_clr);
            end
        end
    end

    task automatic push(input logic [1:0] op, input logic [3:0] len);
        int t;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_len   = len;
        t = 0;
        @(negedge clk);
        while (!cmd_if.cmd_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_if.cmd_ready) begin
            fail("push_timeout");
            cmd_if.cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        sb_q.push_back('{op, len});
        #1 cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int t;
        t = 0;
        @(negedge clk);
        while ((sb_q.size() != 0 || busy) && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (sb_q.size() != 0 || busy) fail("idle_timeout");
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        int t0;
        int nd;
        int t;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = 2'd0;
        cmd_if.cmd_len   = 4'd0;
        err_clr          = 1'b0;

        // Reset state
        #3;
        check("rst_j", j, 0);
        check("rst_k", k, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_count", fifo_count, 0);
        check("rst_ready", cmd_if.cmd_ready, 1);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // SET len=0 latency
        push(2'd1, 4'd0);
        @(negedge clk); check("lat_c1_jk", {j, k}, 2'b00);
        @(negedge clk); check("lat_c2_jk", {j, k}, 2'b00);
        @(negedge clk); check("lat_c3_jk", {j, k}, 2'b10);
        @(negedge clk); check("lat_c4_done", done, 1);
        check("lat_c4_jk", {j, k}, 2'b00);
        check("set_q", q_fb, 1);
        wait_idle(100);

        // TOG len=2 from q=0, then TOG len=3 from q=1
        push(2'd2, 4'd0);
        wait_idle(100);
        push(2'd3, 4'd2);
        wait_idle(100);
        check("tog2_q", q_fb, 1);
        push(2'd3, 4'd3);
        wait_idle(100);
        check("tog3_q", q_fb, 1);

        // Back-to-back: fill FIFO while a long command runs
        push(2'd3, 4'd15);
        repeat (3) @(posedge clk);
        #1;
        check("b2b_count0", fifo_count, 0);
        push(2'd0, 4'd1); check("b2b_count1", fifo_count, 1);
        push(2'd1, 4'd2); check("b2b_count2", fifo_count, 2);
        push(2'd2, 4'd0); check("b2b_count3", fifo_count, 3);
        push(2'd3, 4'd1); check("b2b_count4", fifo_count, 4);
        check("b2b_ready_low", cmd_if.cmd_ready, 0);
        t0 = cyc;
        push(2'd1, 4'd3);
        check("b2b_fifth_waited", (cyc - t0) >= 3, 1);
        check("b2b_count_after5", fifo_count, 4);
        wait_idle(400);

        // Stuck q_fb: mismatch, err_clr collision, then clear alone
        stuck = 1'b1;
        push(2'd1, 4'd0);
        wait_idle(100);
        check("stuck_err_set", err, 1);
        push(2'd1, 4'd1);
        repeat (4) @(posedge clk);
        #1;
        check("clr_cycle_done", done, 1);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        check("err_set_wins", err, 1);
        wait_idle(100);
        stuck = 1'b0;
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        check("err_cleared", err, 0);

        // Randomized commands
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                wait_idle(200);
                stuck = ($urandom_range(0, 1) == 1);
            end
            err_clr = ($urandom_range(0, 5) == 0);
            push(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        err_clr = 1'b0;
        wait_idle(1000);
        stuck = 1'b0;

        // Reset mid-DRIVE of CLR len=7 with two queued
        push(2'd2, 4'd7);
        push(2'd0, 4'd2);
        push(2'd1, 4'd1);
        t = 0;
        @(negedge clk);
        while (!k && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!k) fail("clr_drive_start");
        @(negedge clk);
        #2;
        reset = 1'b0;
        sb_q.delete();
        #1;
        check("rst_mid_j", j, 0);
        check("rst_mid_k", k, 0);
        check("rst_mid_count", fifo_count, 0);
        check("rst_mid_busy", busy, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        nd = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) nd++;
        end
        check("no_done_after_reset", nd, 0);
        check("end_count", fifo_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
